// File: rtl/sdf_pkg.sv
// Shared definitions for the pipelined FFT datapath stages.
//   DEF_WIDTH : default sample component width. The butterfly, the
//               multiplier and the twiddle stages all use it.
//   RS_W      : widest component width that rs() supports.
//   rs()      : round-half-up halving shift with saturation to w bits.
package sdf_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int RS_W      = 32;

    // Argument v holds a sum or difference of two w-bit values, sign-extended
    // to RS_W+2 bits. The result is (v+1)>>>1 clamped to the signed w-bit
    // range and returned in RS_W bits; the caller keeps the low w bits.
    function automatic logic [RS_W-1:0] rs(input logic signed [RS_W+1:0] v, input int w);
        logic signed [RS_W+1:0] one, t, hi, lo;
        one = {{(RS_W+1){1'b0}}, 1'b1};
        t   = (v + one) >>> 1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (t > hi)
            return hi[RS_W-1:0];
        else if (t < lo)
            return lo[RS_W-1:0];
        else
            return t[RS_W-1:0];
    endfunction

endpackage

// File: rtl/delay_buffer.sv
// Enable-gated shift register. It serves as the feedback delay line of an
// SDF stage.
//   clock, reset : clock and asynchronous active-low reset
//   en           : shift enable
//   di           : value pushed on enabled cycles
//   q            : value pushed DEPTH enabled cycles earlier
// Downstream logic masks the contents, so reset is not functionally needed.
// It only makes the contents deterministic after reset.
module delay_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] di,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= di;
            for (int i = 1; i < DEPTH; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage.
//   clock, reset        : clock and asynchronous active-low reset
//   di_en, di_re, di_im : input sample stream (one complex sample per di_en)
//   do_en, do_re, do_im : registered output stream. It carries DEPTH halved
//                         sums and then DEPTH halved differences per frame.
// Phase 0 fills the delay line with new samples and drains the previous
// frame's differences. Phase 1 pairs each input with its partner from
// DEPTH samples earlier.
module sdf_butterfly
    import sdf_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LOG_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int RW    = RS_W + 2;
    localparam logic [LOG_DEPTH:0] CNT_HALF = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0] CNT_ONE  = (LOG_DEPTH+1)'(1);

    // Component index 1 is real, 0 is imaginary.
    logic [1:0][WIDTH-1:0] din, buf_in, buf_out, sum, diff, cand;
    logic [LOG_DEPTH:0]    cnt;
    logic                  phase, primed, primed_next;

    assign din         = {di_re, di_im};
    assign phase       = cnt[LOG_DEPTH];
    assign primed_next = primed | (di_en & (cnt == CNT_HALF));

    for (genvar c = 0; c < 2; c++) begin : g_cmp
        logic signed [WIDTH-1:0] a, b;
        assign a       = buf_out[c];
        assign b       = din[c];
        assign sum[c]  = WIDTH'(rs(RW'(a) + RW'(b), WIDTH));
        assign diff[c] = WIDTH'(rs(RW'(a) - RW'(b), WIDTH));
        assign buf_in[c] = phase ? diff[c] : din[c];
        assign cand[c]   = phase ? sum[c]  : buf_out[c];
    end

    delay_buffer #(.WIDTH(2*WIDTH), .DEPTH(DEPTH)) u_buf (
        .clock (clock),
        .reset (reset),
        .en    (di_en),
        .di    (buf_in),
        .q     (buf_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            primed <= 1'b0;
            do_en  <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
        end else if (di_en) begin
            cnt    <= cnt + CNT_ONE;
            primed <= primed_next;
            do_en  <= primed_next;
            do_re  <= cand[1];
            do_im  <= cand[0];
        end else begin
            do_en  <= 1'b0;
        end
    end

endmodule
